trade_menu_ctrl: RTL
====================

// Module: trade_menu_ctrl
// PURPOSE
//   Parametrised sell-menu controller for the stock game: browse N stocks, enter a sell
//   quantity, confirm, emit one sell transaction, show a timed result message.
//   Sits between board keys/switches and the portfolio/score logic; drives display
//   selection for the HEX decoders. Generalises the two-stock (A/C) sell menu.
// PARAMETERS
//   NUM_STOCKS   2            number of stocks browsed (>=2)
//   QTY_W        8            quantity width (holdings, entry, sold)
//   PRICE_W      12           unit price width
//   HOLD_CYCLES  100_000_000  result-message duration in clocks (2 s @ 50 MHz, >=1)
//   IDX_W        $clog2(NUM_STOCKS)  derived stock index width
// PORTS
//   CLOCK_50     in   1                   system clock
//   reset_n      in   1                   synchronous reset, active-low
//   key_next     in   1                   level, active-high; rising edge = next stock
//   key_sell     in   1                   level; rising edge = enter/leave sell entry
//   key_confirm  in   1                   level; rising edge = confirm sell
//   qty_load     in   1                   level; while high, qty_in captured each clock
//   qty_in       in   QTY_W               requested sell quantity (switches)
//   stock_qty    in   NUM_STOCKS*QTY_W    holdings, stock i at [i*QTY_W +: QTY_W]
//   stock_price  in   NUM_STOCKS*PRICE_W  prices, same packing
//   sell_valid   out  1                   one-cycle pulse: transaction issued
//   sell_idx     out  IDX_W               stock sold (valid with sell_valid)
//   sell_qty     out  QTY_W               quantity sold (valid with sell_valid)
//   sell_total   out  PRICE_W+QTY_W       price*qty, full width, no truncation
//   disp_mode    out  2                   0 BROWSE, 1 ENTRY, 2 DONE, 3 REJECT
//   disp_idx     out  IDX_W               stock currently selected
//   disp_value   out  PRICE_W+QTY_W       zero-extended price / pending qty / sell_total
// BEHAVIOUR
//   - Keys edge-detected internally (registered previous level); one action per press.
//     First clock after reset sees prev=0, so a key held through reset fires once.
//   - Reset (sync, reset_n=0): state BROWSE, sel idx 0, pending 0, timer 0, all outputs 0,
//     disp_mode 0. Reset mid-entry or mid-message discards pending; no sell_valid.
//   - States: BROWSE -> ENTRY on key_sell; ENTRY -> BROWSE on key_sell (pending kept);
//     ENTRY -> DONE or REJECT on key_confirm; DONE/REJECT -> BROWSE after HOLD_CYCLES.
//   - BROWSE: key_next increments sel idx, NUM_STOCKS-1 wraps to 0; disp_value=price[idx].
//   - ENTRY: key_next ignored; disp_value=pending; qty_load high -> pending<=qty_in.
//   - Confirm rule, evaluated against holdings H=stock_qty[idx] on the confirm clock:
//       pending==0 -> REJECT; pending<=H -> DONE, sold=pending; pending>H -> see CONFIG.
//   - DONE entry clock: sell_valid=1 for exactly one cycle, sell_idx/sell_qty/sell_total
//     registered and held until next transaction; pending cleared to 0.
//   - REJECT: no sell_valid; pending retained; disp_value=pending.
//   - Timer: counts 0..HOLD_CYCLES-1 in DONE/REJECT, exits on last count; all keys and
//     qty_load ignored while counting.
//   - Simultaneous edges in one clock: key_sell+key_confirm in ENTRY -> neither acts,
//     stay ENTRY; key_next+key_sell in BROWSE -> key_sell wins, idx unchanged.
//   - qty_load and key_confirm same clock: confirm uses pending value before the load.
//   - All outputs registered; response one clock after the detected edge.
// CONFIGURATION
//   CLAMP_SELL_EN defined  : pending>H -> DONE with sold=H (H==0 -> REJECT).
//   CLAMP_SELL_EN undefined: pending>H -> REJECT, no transaction.
// TESTING (NUM_STOCKS=3, QTY_W=8, PRICE_W=12, HOLD_CYCLES=4)
//   1 reset; key_next x3 -> disp_idx 1,2,0 (wrap); disp_value tracks price of each stock.
//   2 idx1 price=25 H=10; sell, load 4, confirm -> sell_valid 1 cycle, idx1 qty4 total100;
//     disp_mode 2 for 4 clocks then 0.
//   3 H=10, load 12, confirm: CLAMP_SELL_EN -> qty10 total=10*price; else REJECT, no pulse.
//   4 load 0, confirm -> disp_mode 3, no sell_valid; key_next during message ignored.
//   5 key_sell+key_confirm same clock in ENTRY -> stays ENTRY, no pulse.
//   6 reset_n low in ENTRY with pending 7 -> BROWSE, pending 0, outputs 0, no pulse.

Source files
------------

// File: rtl/trade_menu_ctrl.sv
// Sell-menu controller: browse NUM_STOCKS stocks, enter a quantity, confirm, and emit one sell transaction.
// Optional macro CLAMP_SELL_EN: an oversized request sells the full holding instead of being rejected.
module trade_menu_ctrl #(
  parameter int unsigned NUM_STOCKS  = 2,
  parameter int unsigned QTY_W       = 8,
  parameter int unsigned PRICE_W     = 12,
  parameter int unsigned HOLD_CYCLES = 100_000_000,
  parameter int unsigned IDX_W       = $clog2(NUM_STOCKS)
) (
  input  logic                          CLOCK_50,
  input  logic                          reset_n,
  input  logic                          key_next,
  input  logic                          key_sell,
  input  logic                          key_confirm,
  input  logic                          qty_load,
  input  logic [QTY_W-1:0]              qty_in,
  input  logic [NUM_STOCKS*QTY_W-1:0]   stock_qty,
  input  logic [NUM_STOCKS*PRICE_W-1:0] stock_price,
  output logic                          sell_valid,
  output logic [IDX_W-1:0]              sell_idx,
  output logic [QTY_W-1:0]              sell_qty,
  output logic [PRICE_W+QTY_W-1:0]      sell_total,
  output logic [1:0]                    disp_mode,
  output logic [IDX_W-1:0]              disp_idx,
  output logic [PRICE_W+QTY_W-1:0]      disp_value
);

  localparam int unsigned TOT_W = PRICE_W + QTY_W;
  localparam int unsigned TMR_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_BROWSE = 2'd0,
    S_ENTRY  = 2'd1,
    S_DONE   = 2'd2,
    S_REJECT = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [IDX_W-1:0]  sel_idx, idx_n;
  logic [QTY_W-1:0]  pending, pend_n;
  logic [TMR_W-1:0]  timer, tmr_n;
  logic              next_q, sell_q, conf_q;
  logic              next_e, sell_e, conf_e;
  logic              fire;
  logic [QTY_W-1:0]  sold;
  logic [PRICE_W-1:0] cur_price, nxt_price;
  logic [QTY_W-1:0]  cur_hold;
  logic [TOT_W-1:0]  total_calc, total_n, val_n;

  assign next_e = key_next    & ~next_q;
  assign sell_e = key_sell    & ~sell_q;
  assign conf_e = key_confirm & ~conf_q;

  always_comb begin
    cur_price = '0;
    nxt_price = '0;
    cur_hold  = '0;
    for (int unsigned i = 0; i < NUM_STOCKS; i++) begin
      if (sel_idx == IDX_W'(i)) begin
        cur_price = stock_price[i*PRICE_W +: PRICE_W];
        cur_hold  = stock_qty[i*QTY_W +: QTY_W];
      end
      if (idx_n == IDX_W'(i))
        nxt_price = stock_price[i*PRICE_W +: PRICE_W];
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = sel_idx;
    pend_n  = pending;
    tmr_n   = timer;
    fire    = 1'b0;
    sold    = '0;
    unique case (state)
      S_BROWSE: begin
        if (sell_e)
          state_n = S_ENTRY;
        else if (next_e)
          idx_n = (sel_idx == IDX_W'(NUM_STOCKS-1)) ? '0 : sel_idx + 1'b1;
      end
      S_ENTRY: begin
        if (qty_load)
          pend_n = qty_in;
        if (sell_e && !conf_e) begin
          state_n = S_BROWSE;
        end else if (conf_e && !sell_e) begin
          // Decision uses the pre-load pending; an accompanying load is dropped.
          pend_n = pending;
          if (pending == '0) begin
            state_n = S_REJECT;
          end else if (pending <= cur_hold) begin
            state_n = S_DONE;
            fire    = 1'b1;
            sold    = pending;
            pend_n  = '0;
          end else begin
`ifdef CLAMP_SELL_EN
            if (cur_hold == '0) begin
              state_n = S_REJECT;
            end else begin
              state_n = S_DONE;
              fire    = 1'b1;
              sold    = cur_hold;
              pend_n  = '0;
            end
`else
            state_n = S_REJECT;
`endif
          end
        end
      end
      S_DONE, S_REJECT: begin
        if (timer == TMR_W'(HOLD_CYCLES-1)) begin
          state_n = S_BROWSE;
          tmr_n   = '0;
        end else begin
          tmr_n = timer + 1'b1;
        end
      end
      default: state_n = S_BROWSE;
    endcase
  end

  always_comb begin
    total_calc = TOT_W'(cur_price) * TOT_W'(sold);
    total_n    = fire ? total_calc : sell_total;
    unique case (state_n)
      S_BROWSE: val_n = TOT_W'(nxt_price);
      S_DONE:   val_n = total_n;
      default:  val_n = TOT_W'(pend_n);
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state      <= S_BROWSE;
      sel_idx    <= '0;
      pending    <= '0;
      timer      <= '0;
      next_q     <= 1'b0;
      sell_q     <= 1'b0;
      conf_q     <= 1'b0;
      sell_valid <= 1'b0;
      sell_idx   <= '0;
      sell_qty   <= '0;
      sell_total <= '0;
      disp_mode  <= '0;
      disp_idx   <= '0;
      disp_value <= '0;
    end else begin
      state      <= state_n;
      sel_idx    <= idx_n;
      pending    <= pend_n;
      timer      <= tmr_n;
      next_q     <= key_next;
      sell_q     <= key_sell;
      conf_q     <= key_confirm;
      sell_valid <= fire;
      if (fire) begin
        sell_idx <= sel_idx;
        sell_qty <= sold;
      end
      sell_total <= total_n;
      disp_mode  <= state_n;
      disp_idx   <= idx_n;
      disp_value <= val_n;
    end
  end

endmodule
